bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential packed-BCD to binary converter. It is the inverse of the calculator's binary-to-BCD path and uses reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more. It sits between the keypad/switch digit-entry logic and the operand inputs of the operation unit, so operands entered as decimal digits can reach the ALU as binary. The start/ready handshake matches the bin2bcd style used in the calculator datapath.

Parameters:
- DIGITS, 4, number of packed BCD digits at the input (4 bits each).
- BIN_W, 14, output binary width; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 bits covers 9999).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 (ones) is bits [3:0].
- bin_out  output  BIN_W  converted binary; registered; holds its value until the next completed conversion.
- ready  output  1  one-cycle pulse when bin_out/err are updated.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- err  output  1  registered; 1 if the last accepted input had any digit > 9.

Behaviour:
- Reset (async, rst=1): state=IDLE, bin_out=0, ready=0, busy=0, err=0, shift register=0, iteration counter=0. Asserting rst mid-conversion aborts it. No ready pulse is produced for an aborted conversion, and bin_out returns to 0.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - start=1 and all digits <= 9: load shift reg = {bcd_in, BIN_W'b0}, cnt=0, go to CONVERT.
  - start=1 and any digit > 9: go to DONE with an err flag pending.
  - start=0: stay in IDLE.
- CONVERT, each cycle:
  - Shift the whole {bcd, bin} register right by 1.
  - Then, for each BCD nibble of the shifted value that is >= 8, subtract 3 (nibble-local, no borrow between digits).
  - cnt increments. When cnt reaches BIN_W-1 (i.e. BIN_W iterations done), go to DONE.
- DONE, one cycle:
  - bin_out <= low BIN_W bits of the shift register and err <= 0.
  - On the invalid-digit path: bin_out <= 0 and err <= 1.
  - ready=1 for exactly this cycle (registered, asserted on the edge entering DONE). Then return to IDLE.
- busy=1 in CONVERT and DONE.
- Latency, valid input: start sampled at edge E0, ready high in the cycle after edge E0+BIN_W. That is BIN_W+1 cycles from the start edge to the ready cycle (15 for defaults).
- Latency, invalid input: ready high in the cycle after edge E0+1.
- start while busy is ignored (not queued). start held high continuously launches back-to-back conversions, with one IDLE cycle between each.
- bcd_in is sampled only at the accepting edge. Changes during CONVERT have no effect.
- Arithmetic: after BIN_W iterations of a valid input, the BCD field of the shift register is 0. The result is exact for every value 0..10^DIGITS-1. No overflow is possible given the BIN_W constraint.
- An input containing a nibble in 10..15 never produces a nonzero bin_out.
- Implementation: a single always block with async reset, plus a combinational nibble-correction generate loop over DIGITS.

Test Plan:
- rst pulse mid-idle, then bcd_in=16'h0000 with a 1-cycle start -> ready pulses exactly 15 cycles after the start edge, bin_out=0, err=0; busy high for 15 cycles.
- bcd_in=16'h9999, start -> bin_out=14'd9999 (0x270F), err=0. Then bcd_in=16'h1234 -> 0x04D2, and 16'h0128 -> 0x0080.
- bcd_in=16'h12A4, start -> ready pulses 2 cycles after the start edge, bin_out=0, err=1. A following valid 16'h0042 conversion -> bin_out=42, err cleared to 0.
- Start 16'h0500, then pulse start with bcd_in=16'h0777 at cycle 5 of CONVERT -> exactly one ready, bin_out=500; the second start is ignored.
- Start 16'h4321, assert rst at cycle 7 of CONVERT for 1 cycle -> no ready pulse, bin_out=0, busy=0 immediately (async). A subsequent 16'h4321 conversion completes to 4321.
- start held high with bcd_in stepping through 16'h0000 to 16'h0099 after each ready -> every result equals the decimal value; consecutive ready pulses are 16 cycles apart.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle between the digit-entry logic (master) and the BCD-to-binary
// converter (slave).
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  bin_out,
    input  ready,
    input  busy,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output bin_out,
    output ready,
    output busy,
    output err
  );

endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// shift the {bcd, bin} register right, then take 3 off any BCD nibble >= 8.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic         clk,
  input  logic         rst,
  bcd_to_bin_if.slave  bus
);

  localparam int SR_W  = 4 * DIGITS + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [SR_W-1:0]    shift_r;
  logic [SR_W-1:0]    shifted_s;
  logic [SR_W-1:0]    iter_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               err_pend_r;
  logic [BIN_W-1:0]   bin_out_r;
  logic               ready_r;
  logic               busy_r;
  logic               err_r;
  logic               in_valid_s;
  logic               last_iter_s;

  function automatic logic digits_valid(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  assign in_valid_s  = digits_valid(bus.bcd_in);
  assign last_iter_s = (cnt_r == CNT_W'(BIN_W - 1));
  assign shifted_s   = shift_r >> 1;

  // Nibble-local correction; digits never borrow from each other.
  assign iter_s[BIN_W-1:0] = shifted_s[BIN_W-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    assign iter_s[BIN_W + 4*g +: 4] =
      (shifted_s[BIN_W + 4*g +: 4] >= 4'd8) ? (shifted_s[BIN_W + 4*g +: 4] - 4'd3)
                                             : shifted_s[BIN_W + 4*g +: 4];
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = in_valid_s ? CONVERT : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        if (last_iter_s) begin
          state_s = DONE;
        end else begin
          state_s = CONVERT;
        end
      end
      DONE: begin
        // A rejected input spends one cycle here before its result is published.
        if (err_pend_r) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, shift datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {SR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      err_pend_r <= 1'b0;
      bin_out_r  <= {BIN_W{1'b0}};
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (in_valid_s) begin
              shift_r <= {bus.bcd_in, {BIN_W{1'b0}}};
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              err_pend_r <= 1'b1;
            end
          end
        end
        CONVERT: begin
          shift_r <= iter_s;
          cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_iter_s) begin
            bin_out_r <= iter_s[BIN_W-1:0];
            err_r     <= 1'b0;
            ready_r   <= 1'b1;
          end
        end
        DONE: begin
          if (err_pend_r) begin
            bin_out_r  <= {BIN_W{1'b0}};
            err_r      <= 1'b1;
            ready_r    <= 1'b1;
            err_pend_r <= 1'b0;
          end
        end
        default: begin
          err_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bin_out = bin_out_r;
  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: expected results are queued at launch and
// compared by a monitor whenever ready pulses.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n0 = 0;
  int   ready_count = 0;
  exp_t exp_q[$];

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      ready_count <= ready_count + 1;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("bin_out", 32'(bus.bin_out), 32'(exp_q[0].bin));
        check("err", 32'(bus.err), 32'(exp_q[0].err));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic launch(input logic [15:0] bcd, input int exp_bin, input logic exp_err);
    exp_t e;
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    e.bin = BIN_W'(exp_bin);
    e.err = exp_err;
    exp_q.push_back(e);
    bus.start  = 1'b0;
    bus.bcd_in = 16'h9999;
  endtask

  task automatic wait_ready(input int exp_lat, input int exp_busy);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.ready === 1'b1) seen = 1'b1;
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cyc - n0), 32'(exp_lat));
      if (exp_busy >= 0) check("busy_cycles", 32'(busy_n), 32'(exp_busy));
      @(negedge clk);
      check("ready_one_cycle", 32'(bus.ready), 32'd0);
      check("busy_low_after", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int rc;
    int prev;
    bit seen;
    exp_t e;

    bus.start  = 1'b0;
    bus.bcd_in = 16'h0000;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bin_out", 32'(bus.bin_out), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    launch(16'h0000, 0, 1'b0);
    wait_ready(14, 15);
    launch(16'h9999, 9999, 1'b0);
    wait_ready(14, -1);
    launch(16'h1234, 1234, 1'b0);
    wait_ready(14, -1);
    launch(16'h0128, 128, 1'b0);
    wait_ready(14, -1);

    launch(16'h12A4, 0, 1'b1);
    wait_ready(1, 2);
    launch(16'h0042, 42, 1'b0);
    wait_ready(14, -1);

    // A start raised mid-conversion must be ignored.
    rc = ready_count;
    launch(16'h0500, 500, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0777;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_ready(14, -1);
    repeat (20) @(negedge clk);
    check("single_ready", 32'(ready_count - rc), 32'd1);

    // Reset mid-conversion aborts without a ready pulse.
    launch(16'h4321, 4321, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_bin_out", 32'(bus.bin_out), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    exp_q.delete();
    rc = ready_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("no_ready_abort", 32'(ready_count - rc), 32'd0);
    launch(16'h4321, 4321, 1'b0);
    wait_ready(14, -1);

    // start held high: back-to-back conversions 16 cycles apart.
    bus.start = 1'b1;
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      bus.bcd_in = enc(i);
      e.bin = BIN_W'(i);
      e.err = 1'b0;
      exp_q.push_back(e);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (bus.ready === 1'b1) seen = 1'b1;
      end
      check("held_ready_seen", 32'(seen), 32'd1);
      if (seen && i > 0) check("ready_spacing", 32'(cyc - prev), 32'd16);
      prev = cyc;
    end
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
